gate_bist_controller: RTL and testbench

Built-in self-test sequencer for the 15-input / 10-output combinational gate models in the gate library. It drives a pseudo-random 15-bit stimulus into the model's inputs N1..N15, waits a programmable settle time, and compacts the 10 outputs into a signature register. It sits between the lab-board control logic (start/done handshake) and one gate-model instance, so students' netlists can be checked against a golden signature without per-vector comparison.

---
 rtl/gate_bist_controller.sv | 154 +++++++++++++++
 tb/tb_gate_bist_controller.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_bist_controller.sv
// gate_bist_controller
// BIST sequencer for the 15-input / 10-output gate models: drives an LFSR
// stimulus onto the model inputs, holds each vector for a programmable settle
// time, then folds the model outputs into a 10-bit MISR signature.
//
// Optional feature macro: GATE_BIST_SIG_CMP_EN
//   defined   -> pass_o reports (final signature == EXPECTED_SIG), latched on
//                entry to DONE and cleared on the next start or reset.
//   undefined -> no compare logic; pass_o is tied low and signature_o is the
//                only result.
module gate_bist_controller #(
    parameter logic [15:0] NUM_PATTERNS  = 16'd256,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [14:0] SEED          = 15'h0001,
    parameter logic [9:0]  EXPECTED_SIG  = 10'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [9:0]  response_i,
    output logic [14:0] pattern_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [9:0]  signature_o,
    output logic [15:0] count_o,
    output logic        pass_o
);

    // An all-zero LFSR state would lock up, so a zero seed falls back to 1.
    localparam logic [14:0] LFSR_INIT   = (SEED == 15'h0000) ? 15'h0001 : SEED;
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [9:0]  MISR_POLY   = 10'h009;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Fibonacci LFSR, x^15 + x^14 + 1.
    function automatic logic [14:0] lfsr_next(input logic [14:0] q);
        return {q[13:0], q[14] ^ q[13]};
    endfunction

    // MISR, x^10 + x^3 + 1, with the response folded in after the shift.
    function automatic logic [9:0] misr_next(input logic [9:0] m, input logic [9:0] r);
        return ({m[8:0], 1'b0} ^ (m[9] ? MISR_POLY : 10'h000)) ^ r;
    endfunction

    state_t      r_state;
    logic [14:0] r_lfsr;
    logic [9:0]  r_misr;
    logic [15:0] r_count;
    logic [3:0]  r_settle_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;

    logic [14:0] w_lfsr_next;
    logic [9:0]  w_misr_next;
    logic [15:0] w_count_next;
    logic        w_last_pattern;
    logic        w_sig_match;

    assign w_lfsr_next    = lfsr_next(r_lfsr);
    assign w_misr_next    = misr_next(r_misr, response_i);
    assign w_count_next   = r_count + 16'd1;
    assign w_last_pattern = (w_count_next == NUM_PATTERNS);

`ifdef GATE_BIST_SIG_CMP_EN
    // The verdict looks at the signature the final capture is about to write.
    assign w_sig_match = (w_misr_next == EXPECTED_SIG);
`else
    // No compare in this build; the golden value is deliberately left unused.
    logic [9:0] w_unused_expected_sig;
    assign w_unused_expected_sig = EXPECTED_SIG;
    assign w_sig_match           = 1'b0;
`endif

    // Run sequencer: state, stimulus LFSR, signature MISR and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_lfsr       <= '0;
            r_misr       <= '0;
            r_count      <= '0;
            r_settle_cnt <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // abort_i alongside start_i cancels the request.
                    if (start_i && !abort_i) begin
                        r_lfsr       <= LFSR_INIT;
                        r_misr       <= '0;
                        r_count      <= '0;
                        r_settle_cnt <= '0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (abort_i) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 4'd1;
                        if (r_settle_cnt == SETTLE_LAST) begin
                            r_state <= S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    // Abort takes priority: the pending capture is discarded.
                    if (abort_i) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_misr       <= w_misr_next;
                        r_count      <= w_count_next;
                        r_lfsr       <= w_lfsr_next;
                        r_settle_cnt <= '0;
                        if (w_last_pattern) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= w_sig_match;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SETTLE;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pattern_o   = r_lfsr;
    assign signature_o = r_misr;
    assign count_o     = r_count;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign pass_o      = r_pass;

endmodule

// File: tb/tb_gate_bist_controller.sv
// Testbench for gate_bist_controller: two instances (A: 4 patterns, settle 2,
// seed 1, golden 0x00F; B: 16 patterns, settle 1, seed 0) driven with timed
// stimulus; expected captures and end-of-run results are queued by the
// stimulus and consumed by per-instance monitors on the falling edge.
module tb_gate_bist_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_start, a_abort;
    logic [9:0]  a_resp;
    logic [14:0] a_pat;
    logic        a_busy, a_done, a_pass;
    logic [9:0]  a_sig;
    logic [15:0] a_cnt;

    logic        b_rst, b_start, b_abort;
    logic [9:0]  b_resp;
    logic [14:0] b_pat;
    logic        b_busy, b_done, b_pass;
    logic [9:0]  b_sig;
    logic [15:0] b_cnt;

    gate_bist_controller #(
        .NUM_PATTERNS (16'd4),
        .SETTLE_CYCLES(2),
        .SEED         (15'h0001),
        .EXPECTED_SIG (10'h00F)
    ) u_dut_a (
        .clk        (clk),
        .rst        (a_rst),
        .start_i    (a_start),
        .abort_i    (a_abort),
        .response_i (a_resp),
        .pattern_o  (a_pat),
        .busy_o     (a_busy),
        .done_o     (a_done),
        .signature_o(a_sig),
        .count_o    (a_cnt),
        .pass_o     (a_pass)
    );

    gate_bist_controller #(
        .NUM_PATTERNS (16'd16),
        .SETTLE_CYCLES(1),
        .SEED         (15'h0000),
        .EXPECTED_SIG (10'h000)
    ) u_dut_b (
        .clk        (clk),
        .rst        (b_rst),
        .start_i    (b_start),
        .abort_i    (b_abort),
        .response_i (b_resp),
        .pattern_o  (b_pat),
        .busy_o     (b_busy),
        .done_o     (b_done),
        .signature_o(b_sig),
        .count_o    (b_cnt),
        .pass_o     (b_pass)
    );

    typedef struct packed {
        logic [15:0] cnt;
        logic [9:0]  sig;
        logic [14:0] pat;
    } cap_t;

    typedef struct packed {
        logic [15:0] cnt;
        logic [9:0]  sig;
        logic        pass;
    } fin_t;

    typedef struct packed {
        logic [14:0] pat;
        logic        busy;
        logic        done;
        logic [9:0]  sig;
        logic [15:0] cnt;
        logic        pass;
    } obs_t;

    cap_t capq0[$];
    cap_t capq1[$];
    fin_t finq0[$];
    fin_t finq1[$];

    int   n_checks = 0;
    int   n_errors = 0;
    logic mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: DUT presented a result with nothing queued", name);
    endtask

    // ---------------- reference model (spec rules as plain arithmetic) ----------------
    function automatic int np(input int w);
        return (w == 0) ? 4 : 16;
    endfunction

    function automatic int sc(input int w);
        return (w == 0) ? 2 : 1;
    endfunction

    function automatic logic [14:0] seed_eff(input int w);
        logic [14:0] sd;
        sd = (w == 0) ? 15'h0001 : 15'h0000;
        return (sd == 15'h0000) ? 15'h0001 : sd;
    endfunction

    function automatic logic [9:0] golden(input int w);
        return (w == 0) ? 10'h00F : 10'h000;
    endfunction

    function automatic logic [14:0] m_lfsr(input logic [14:0] q);
        int v;
        int fb;
        v  = int'(q);
        fb = ((v >> 14) ^ (v >> 13)) & 1;
        return 15'(((v * 2) % 32768) + fb);
    endfunction

    function automatic logic [9:0] m_misr(input logic [9:0] m, input logic [9:0] r);
        int v;
        v = int'(m) * 2;
        if (v >= 1024) v = (v - 1024) ^ 9;
        return 10'(v) ^ r;
    endfunction

    // ---------------- DUT access helpers ----------------
    function automatic obs_t obs(input int w);
        obs_t o;
        if (w == 0) begin
            o.pat = a_pat; o.busy = a_busy; o.done = a_done;
            o.sig = a_sig; o.cnt = a_cnt;   o.pass = a_pass;
        end else begin
            o.pat = b_pat; o.busy = b_busy; o.done = b_done;
            o.sig = b_sig; o.cnt = b_cnt;   o.pass = b_pass;
        end
        return o;
    endfunction

    task automatic set_ctl(input int w, input logic r, input logic s, input logic a);
        if (w == 0) begin
            a_rst = r; a_start = s; a_abort = a;
        end else begin
            b_rst = r; b_start = s; b_abort = a;
        end
    endtask

    task automatic set_resp(input int w, input logic [9:0] r);
        if (w == 0) a_resp = r;
        else        b_resp = r;
    endtask

    task automatic check_all_zero(input int w, input string tag);
        obs_t o;
        o = obs(w);
        check({tag, " pattern"}, 32'(o.pat), 32'h0);
        check({tag, " busy"},    32'(o.busy), 32'h0);
        check({tag, " done"},    32'(o.done), 32'h0);
        check({tag, " sig"},     32'(o.sig), 32'h0);
        check({tag, " count"},   32'(o.cnt), 32'h0);
        check({tag, " pass"},    32'(o.pass), 32'h0);
    endtask

    // ---------------- monitors ----------------
    logic [15:0] a_prev_cnt  = '0;
    logic        a_prev_done = 1'b0;
    logic [15:0] b_prev_cnt  = '0;
    logic        b_prev_done = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (a_cnt != a_prev_cnt && a_cnt != 16'd0) begin
                if (capq0.size() == 0) unexpected("A capture");
                else begin
                    check("A cap count",   32'(a_cnt), 32'(capq0[0].cnt));
                    check("A cap sig",     32'(a_sig), 32'(capq0[0].sig));
                    check("A cap pattern", 32'(a_pat), 32'(capq0[0].pat));
                    void'(capq0.pop_front());
                end
            end
            if (a_done && !a_prev_done) begin
                if (finq0.size() == 0) unexpected("A done");
                else begin
                    check("A final count", 32'(a_cnt),  32'(finq0[0].cnt));
                    check("A final sig",   32'(a_sig),  32'(finq0[0].sig));
                    check("A final pass",  32'(a_pass), 32'(finq0[0].pass));
                    void'(finq0.pop_front());
                end
            end
        end
        a_prev_cnt  <= a_cnt;
        a_prev_done <= a_done;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (b_cnt != b_prev_cnt && b_cnt != 16'd0) begin
                if (capq1.size() == 0) unexpected("B capture");
                else begin
                    check("B cap count",   32'(b_cnt), 32'(capq1[0].cnt));
                    check("B cap sig",     32'(b_sig), 32'(capq1[0].sig));
                    check("B cap pattern", 32'(b_pat), 32'(capq1[0].pat));
                    void'(capq1.pop_front());
                end
            end
            if (b_done && !b_prev_done) begin
                if (finq1.size() == 0) unexpected("B done");
                else begin
                    check("B final count", 32'(b_cnt),  32'(finq1[0].cnt));
                    check("B final sig",   32'(b_sig),  32'(finq1[0].sig));
                    check("B final pass",  32'(b_pass), 32'(finq1[0].pass));
                    void'(finq1.pop_front());
                end
            end
        end
        b_prev_cnt  <= b_cnt;
        b_prev_done <= b_done;
    end

    // ---------------- run driver ----------------
    // rmode: 0 random responses, 1 constant 0x001, 2 constant 0x000.
    // glitch_k/abort_k/rst_k select the pattern index for a start pulse,
    // an abort at the capture edge, or a two-cycle reset (0 = none).
    task automatic run(input int w, input int rmode, input int glitch_k,
                       input int abort_k, input int rst_k);
        int          n;
        int          s;
        logic [14:0] q;
        logic [14:0] nq;
        logic [9:0]  m;
        logic [9:0]  nm;
        logic [9:0]  r;
        logic        pass_e;
        obs_t        o;
        string       tag;
        cap_t        ce;
        fin_t        fe;

        n   = np(w);
        s   = sc(w);
        q   = seed_eff(w);
        m   = '0;
        tag = (w == 0) ? "A" : "B";

        set_ctl(w, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        set_ctl(w, 1'b0, 1'b0, 1'b0);
        o = obs(w);
        check({tag, " start busy"},    32'(o.busy), 32'h1);
        check({tag, " start done"},    32'(o.done), 32'h0);
        check({tag, " start count"},   32'(o.cnt),  32'h0);
        check({tag, " start sig"},     32'(o.sig),  32'h0);
        check({tag, " start pattern"}, 32'(o.pat),  32'(q));
        if (w == 1) check("B zero seed replaced", 32'(o.pat), 32'h0001);

        for (int k = 1; k <= n; k++) begin
            case (rmode)
                0:       r = 10'($urandom);
                1:       r = 10'h001;
                default: r = 10'h000;
            endcase
            set_resp(w, r);
            nm = m_misr(m, r);
            nq = m_lfsr(q);
            if (k != abort_k && k != rst_k) begin
                ce.cnt = 16'(k); ce.sig = nm; ce.pat = nq;
                if (w == 0) capq0.push_back(ce);
                else        capq1.push_back(ce);
                if (k == n) begin
`ifdef GATE_BIST_SIG_CMP_EN
                    pass_e = (nm == golden(w));
`else
                    pass_e = 1'b0;
`endif
                    fe.cnt = 16'(n); fe.sig = nm; fe.pass = pass_e;
                    if (w == 0) finq0.push_back(fe);
                    else        finq1.push_back(fe);
                end
            end

            for (int c = 0; c <= s; c++) begin
                if (k == rst_k)
                    set_ctl(w, (c < 2) ? 1'b1 : 1'b0, 1'b0, 1'b0);
                else if (k == abort_k && c == s)
                    set_ctl(w, 1'b0, 1'b0, 1'b1);
                else if (k == glitch_k && c == 0)
                    set_ctl(w, 1'b0, 1'b1, 1'b0);
                else
                    set_ctl(w, 1'b0, 1'b0, 1'b0);
                @(posedge clk); #1;
            end
            set_ctl(w, 1'b0, 1'b0, 1'b0);
            o = obs(w);

            if (k == rst_k) begin
                check_all_zero(w, {tag, " mid-run reset"});
                return;
            end
            if (k == abort_k) begin
                check({tag, " abort busy"},    32'(o.busy), 32'h0);
                check({tag, " abort done"},    32'(o.done), 32'h0);
                check({tag, " abort count"},   32'(o.cnt),  32'(k - 1));
                check({tag, " abort sig"},     32'(o.sig),  32'(m));
                check({tag, " abort pattern"}, 32'(o.pat),  32'(q));
                return;
            end

            m = nm;
            q = nq;
            if (k < n) begin
                check({tag, " busy mid-run"}, 32'(o.busy), 32'h1);
                check({tag, " done mid-run"}, 32'(o.done), 32'h0);
            end else begin
                check({tag, " busy at end"},  32'(o.busy), 32'h0);
                check({tag, " done at end"},  32'(o.done), 32'h1);
                check({tag, " count at end"}, 32'(o.cnt),  32'(n));
            end
            if (w == 0 && rmode == 1 && k == 1) check("A sig after 1 capture", 32'(o.sig), 32'h001);
            if (w == 0 && rmode == 1 && k == 2) check("A sig after 2 captures", 32'(o.sig), 32'h003);
            if (w == 1 && rmode == 2 && k == 13) check("B pattern 13", 32'(o.pat), 32'h2000);
            if (w == 1 && rmode == 2 && k == 14) check("B pattern 14", 32'(o.pat), 32'h4001);
            if (w == 1 && rmode == 2) check("B sig with zero response", 32'(o.sig), 32'h000);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        obs_t o;
        set_ctl(0, 1'b1, 1'b0, 1'b0);
        set_ctl(1, 1'b1, 1'b0, 1'b0);
        set_resp(0, 10'h000);
        set_resp(1, 10'h000);
        repeat (2) @(posedge clk);
        #1;
        check_all_zero(0, "A reset");
        check_all_zero(1, "B reset");
        set_ctl(0, 1'b0, 1'b0, 1'b0);
        set_ctl(1, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Constant response, start pulse mid-run ignored, pass verdict.
        run(0, 1, 2, 0, 0);
`ifdef GATE_BIST_SIG_CMP_EN
        check("A pass with golden match", 32'(a_pass), 32'h1);
`else
        check("A pass tied low", 32'(a_pass), 32'h0);
`endif

        // start together with abort in DONE is ignored.
        set_ctl(0, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        set_ctl(0, 1'b0, 1'b0, 1'b0);
        o = obs(0);
        check("A start+abort in DONE done", 32'(o.done), 32'h1);
        check("A start+abort in DONE busy", 32'(o.busy), 32'h0);
        check("A start+abort in DONE count", 32'(o.cnt), 32'h4);

        // Back-to-back random runs.
        run(0, 0, 0, 0, 0);
        run(0, 0, 0, 0, 0);

        // Abort at the second capture, then abort alone in IDLE.
        run(0, 0, 0, 2, 0);
        set_ctl(0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        set_ctl(0, 1'b0, 1'b0, 1'b0);
        check("A abort in IDLE busy", 32'(a_busy), 32'h0);
        check("A abort in IDLE count", 32'(a_cnt), 32'h1);

        // Reset mid-run, then a full run from the seed.
        run(0, 0, 0, 0, 2);
        run(0, 0, 0, 0, 0);

        // Long run on B: LFSR sequence with zero response, then random.
        run(1, 2, 0, 0, 0);
        run(1, 0, 0, 0, 0);
        run(1, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("A scoreboard drained", 32'(capq0.size() + finq0.size()), 32'h0);
        check("B scoreboard drained", 32'(capq1.size() + finq1.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
